div_5_serializer: RTL and testbench

- Bit-serial transmitter feeding the divisible-by-5 detector.
- Accepts W-bit words over a valid/ready handshake and shifts them out MSB-first, one bit per clock, on a continuous stream.
- Keeps a running mod-5 residue of every bit emitted since the last clear, plus an expected-divisible flag.
- Serves both as stimulus source and as golden reference for the detector, in bench and on-chip self-test.

---
 rtl/div_5_pkg.sv | 21 ++
 rtl/div_5_serializer_accumulator.sv | 35 +++
 rtl/div_5_serializer.sv | 86 ++++++++
 tb/tb_div_5_serializer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_5_pkg.sv
// Shared types and the mod-5 step used by the serializer, the detector and benches.
package div_5_pkg;

  localparam int unsigned MOD_DIV = 5;

  typedef logic [2:0] residue_t;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  // {r, b} is 2*r + b; a single conditional subtract keeps it in 0..4 since the max is 9.
  function automatic residue_t mod5_step(residue_t r, logic b);
    logic [3:0] t;
    t = {r, b};
    if (t >= 4'(MOD_DIV)) t = t - 4'(MOD_DIV);
    return t[2:0];
  endfunction

endpackage

// File: rtl/div_5_serializer_accumulator.sv
// Running mod-5 residue of the emitted bit stream plus the expected-divisible flag.
module mod_5_accumulator
  import div_5_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     step_en,
  input  logic     clear_en,
  input  logic     data_bit,
  output residue_t residue,
  output logic     div_5_exp
);

  logic     one_seen;
  residue_t residue_nxt;
  logic     one_nxt;

  always_comb begin
    residue_nxt = mod5_step(clear_en ? residue_t'('0) : residue, data_bit);
    one_nxt     = (one_seen & ~clear_en) | data_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      residue   <= '0;
      one_seen  <= 1'b0;
      div_5_exp <= 1'b0;
    end else if (step_en) begin
      residue   <= residue_nxt;
      one_seen  <= one_nxt;
      div_5_exp <= (residue_nxt == '0) & one_nxt;
    end
  end

endmodule

// File: rtl/div_5_serializer.sv
// MSB-first word serializer with a golden mod-5 reference for the divisible-by-5 detector.
module div_5_serializer
  import div_5_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         word_valid,
  output logic         word_ready,
  input  logic [W-1:0] word_data,
  input  logic         word_clear,
  output logic         out_bit,
  output logic         out_valid,
  output logic         out_last,
  output logic [2:0]   residue,
  output logic         div_5_exp
);

  localparam int unsigned CW = $clog2(W);

  state_t        state, state_nxt;
  logic [W-1:0]  shreg;
  logic [CW-1:0] bit_cnt;
  logic          clr_pend;
  logic          accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    word_ready = 1'b0;
    out_valid  = 1'b0;
    out_bit    = 1'b0;
    out_last   = 1'b0;
    case (state)
      IDLE: begin
        word_ready = 1'b1;
        if (word_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        out_valid = 1'b1;
        out_bit   = shreg[W-1];
        if (bit_cnt == CW'(W - 1)) begin
          // Ready during the LSB cycle lets the next word follow with no bubble.
          out_last   = 1'b1;
          word_ready = 1'b1;
          state_nxt  = word_valid ? SHIFT : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = word_valid & word_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      clr_pend <= 1'b0;
    end else if (accept) begin
      shreg    <= word_data;
      bit_cnt  <= '0;
      clr_pend <= word_clear;
    end else if (out_valid) begin
      shreg    <= {shreg[W-2:0], 1'b0};
      bit_cnt  <= bit_cnt + 1'b1;
      clr_pend <= 1'b0;
    end
  end

  mod_5_accumulator u_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .step_en   (out_valid),
    .clear_en  (out_valid & clr_pend),
    .data_bit  (out_bit),
    .residue   (residue),
    .div_5_exp (div_5_exp)
  );

endmodule

// File: tb/tb_div_5_serializer.sv
// Directed, table-driven bench for div_5_serializer (W=8) with a per-cycle stream model.
module tb_div_5_serializer;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         word_valid;
  logic         word_ready;
  logic [W-1:0] word_data;
  logic         word_clear;
  logic         out_bit;
  logic         out_valid;
  logic         out_last;
  logic [2:0]   residue;
  logic         div_5_exp;

  div_5_serializer #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_data  (word_data),
    .word_clear (word_clear),
    .out_bit    (out_bit),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .residue    (residue),
    .div_5_exp  (div_5_exp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0]  data;
    logic        clear;
    int unsigned gap;
    logic [2:0]  fres;
    logic        fdiv;
  } vec_t;

  typedef struct {
    logic       b;
    logic       last;
    logic       clr;
    logic [2:0] fres;
    logic       fdiv;
  } bit_t;

  bit_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         mval = 0;
  logic       mone = 1'b0;
  logic       mdiv = 1'b0;
  logic       exp_ready = 1'b1;
  logic       fin_pend = 1'b0;
  logic [2:0] fin_res = '0;
  logic       fin_div = 1'b0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: compare this cycle's outputs at the falling edge, advance the model, idle inputs.
  task automatic tick();
    bit_t e;
    @(negedge clk);
    chk("residue", residue, 8'(mval));
    chk("div_5_exp", div_5_exp, mdiv);
    if (fin_pend) begin
      chk("final_residue", residue, fin_res);
      chk("final_div_5_exp", div_5_exp, fin_div);
      fin_pend = 1'b0;
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("out_valid", out_valid, 1'b1);
      chk("out_bit", out_bit, e.b);
      chk("out_last", out_last, e.last);
      if (e.clr) begin
        mval = 0;
        mone = 1'b0;
      end
      mval = (mval * 2 + int'(e.b)) % 5;
      mone = mone | e.b;
      mdiv = (mval == 0) && mone;
      if (e.last) begin
        fin_pend = 1'b1;
        fin_res  = e.fres;
        fin_div  = e.fdiv;
      end
    end else begin
      chk("idle_out_valid", out_valid, 1'b0);
      chk("idle_out_bit", out_bit, 1'b0);
      chk("idle_out_last", out_last, 1'b0);
    end
    exp_ready = (q.size() == 0);
    chk("word_ready", word_ready, exp_ready);
    word_valid = 1'b0;
    word_clear = 1'b0;
    word_data  = '0;
  endtask

  task automatic send(input logic [7:0] data, input logic clear, input int unsigned gap,
                      input logic [2:0] fres, input logic fdiv);
    bit_t        e;
    int unsigned n;
    int unsigned guard;
    bit          done;
    n = 0;
    guard = 0;
    done = 0;
    while (!done) begin
      tick();
      guard++;
      if (guard > 40) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: word_ready never seen for word %0d", data);
        return;
      end
      if (exp_ready) begin
        if (n >= gap) done = 1;
        else n++;
      end else if (gap == 0) begin
        // Hold valid high while busy; the flipped clear must be ignored since nothing is accepted.
        word_valid = 1'b1;
        word_data  = data;
        word_clear = ~clear;
      end
    end
    word_valid = 1'b1;
    word_data  = data;
    word_clear = clear;
    for (int j = 0; j < 8; j++) begin
      e.b    = data[7-j];
      e.last = (j == 7);
      e.clr  = (j == 0) && clear;
      e.fres = fres;
      e.fdiv = fdiv;
      q.push_back(e);
    end
  endtask

  task automatic drain();
    int unsigned guard;
    guard = 0;
    while ((q.size() > 0 || fin_pend) && guard < 40) begin
      tick();
      guard++;
    end
    tick();
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{data: 8'h05, clear: 1'b1, gap: 0, fres: 3'd0, fdiv: 1'b1};
    vecs[1] = '{data: 8'h0A, clear: 1'b1, gap: 2, fres: 3'd0, fdiv: 1'b1};
    vecs[2] = '{data: 8'h00, clear: 1'b0, gap: 0, fres: 3'd0, fdiv: 1'b1}; // 2560
    vecs[3] = '{data: 8'h07, clear: 1'b1, gap: 2, fres: 3'd2, fdiv: 1'b0};
    vecs[4] = '{data: 8'h03, clear: 1'b0, gap: 0, fres: 3'd0, fdiv: 1'b1}; // 1795
    vecs[5] = '{data: 8'h00, clear: 1'b1, gap: 1, fres: 3'd0, fdiv: 1'b0};
    vecs[6] = '{data: 8'h0D, clear: 1'b1, gap: 1, fres: 3'd3, fdiv: 1'b0};
    vecs[7] = '{data: 8'h02, clear: 1'b0, gap: 4, fres: 3'd0, fdiv: 1'b1}; // 3330
    vecs[8] = '{data: 8'hFF, clear: 1'b1, gap: 1, fres: 3'd0, fdiv: 1'b1};

    rst_n      = 1'b0;
    word_valid = 1'b0;
    word_data  = '0;
    word_clear = 1'b0;
    #12;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_residue", residue, 3'd0);
    chk("reset_word_ready", word_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++)
      send(vecs[i].data, vecs[i].clear, vecs[i].gap, vecs[i].fres, vecs[i].fdiv);
    drain();

    // Reset three bits into 0xFF: residue is 2 at that point, so the clear is observable.
    send(8'hFF, 1'b1, 1, 3'd0, 1'b1);
    tick();
    tick();
    tick();
    tick();
    #2;
    chk("pre_reset_residue", residue, 3'd2);
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 1'b0);
    chk("async_out_bit", out_bit, 1'b0);
    chk("async_residue", residue, 3'd0);
    chk("async_div_5_exp", div_5_exp, 1'b0);
    chk("async_word_ready", word_ready, 1'b1);
    q.delete();
    mval = 0;
    mone = 1'b0;
    mdiv = 1'b0;
    fin_pend = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    send(8'h05, 1'b0, 1, 3'd0, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
